// File: rtl/decade_count_ctrl.sv
// Sequencing controller for the 4-bit decade counter datapath: button edge
// detection, START/PAUSE/DONE sequencing and prescaled count-enable generation.
module decade_count_ctrl #(
  parameter int PRESCALE  = 4,
  parameter int MAX_DIGIT = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic [3:0] target,
  input  logic [3:0] cnt_value,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       running,
  output logic       done,
  output logic       wrap_pulse
);

  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [3:0]      MAX_VAL    = 4'(MAX_DIGIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;

  // Per-button pipeline, bit order {clear, stop, start}: s1/s2 resynchronise the
  // raw level, s3 is the one-cycle delay that turns a rising edge into an event.
  logic [2:0] btn;
  logic [2:0] s1, s2, s3;
  logic [2:0] evt;
  logic       evt_start, evt_stop, evt_clear;

  assign btn = {btn_clear, btn_stop, btn_start};

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (s1->s2->s3 stays a pipeline).
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign evt       = s2 & ~s3;
  assign evt_start = evt[0];
  assign evt_stop  = evt[1];
  assign evt_clear = evt[2];

  logic tick;
  logic hit;

  assign tick       = (state == RUN) && (presc == PRESC_LAST);
  assign hit        = (cnt_value == target);
  assign cnt_en     = tick & ~hit & ~cnt_clr;
  assign wrap_pulse = cnt_en & (cnt_value == MAX_VAL);
  assign running    = (state == RUN);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      presc   <= '0;
      cnt_clr <= 1'b0;
    end else begin
      cnt_clr <= 1'b0;
      if (evt_clear) begin
        state   <= IDLE;
        presc   <= '0;
        cnt_clr <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (evt_start) begin
              state <= RUN;
              presc <= '0;
            end
          end
          RUN: begin
            if (evt_stop) begin
              state <= PAUSE;
            end else if (tick && hit) begin
              // Halt before the increment so the datapath keeps showing target.
              state <= DONE;
            end else if (presc == PRESC_LAST) begin
              presc <= '0;
            end else begin
              presc <= presc + PW'(1);
            end
          end
          PAUSE: begin
            if (evt_start) state <= RUN;
          end
          DONE: begin
            if (evt_start) begin
              state   <= RUN;
              presc   <= '0;
              cnt_clr <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decade_count_ctrl.sv
// Directed bench for decade_count_ctrl with a behavioural decade-counter datapath
// closing the loop between cnt_en/cnt_clr and cnt_value.
module tb_decade_count_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_start, btn_stop, btn_clear;
  logic [3:0] target;
  logic [3:0] cnt_value;
  logic       cnt_en, cnt_clr, running, done, wrap_pulse;

  int checks = 0;
  int errors = 0;

  decade_count_ctrl #(.PRESCALE(4), .MAX_DIGIT(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_stop   (btn_stop),
    .btn_clear  (btn_clear),
    .target     (target),
    .cnt_value  (cnt_value),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .running    (running),
    .done       (done),
    .wrap_pulse (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: synchronous clear, increment on enable, wrap 9 -> 0.
  always @(posedge clk) begin
    if (reset)        cnt_value <= 4'd0;
    else if (cnt_clr) cnt_value <= 4'd0;
    else if (cnt_en)  cnt_value <= (cnt_value == 4'd9) ? 4'd0 : cnt_value + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  int  en_cnt, wrap_cnt, first_en;
  bit  done_seen, found;

  initial begin
    reset = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; btn_clear = 1'b0; target = 4'd5;
    repeat (3) step();
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_cnt_en", cnt_en, 0);
    check("rst_cnt_clr", cnt_clr, 0);
    reset = 1'b0;
    step();

    // 1: target 5, start pulse; RUN two edges after the sampling edge.
    btn_start = 1'b1; step();
    check("t1_run_n", running, 0);
    btn_start = 1'b0; step();
    check("t1_run_n1", running, 0);
    step();
    check("t1_run_n2", running, 1);
    en_cnt = 0; first_en = -1;
    for (int c = 0; c < 24; c++) begin
      if (cnt_en) begin
        en_cnt++;
        if (first_en < 0) first_en = c;
      end
      if (c == 3)  check("t1_first_en_val", cnt_value, 0);
      if (c == 23) begin
        check("t1_hit_no_en", cnt_en, 0);
        check("t1_hit_val", cnt_value, 5);
      end
      step();
    end
    check("t1_first_en_cycle", first_en, 3);
    check("t1_en_count", en_cnt, 5);
    check("t1_done", done, 1);
    check("t1_not_running", running, 0);
    repeat (5) step();
    check("t1_hold_val", cnt_value, 5);
    check("t1_hold_en", cnt_en, 0);

    // Restart from DONE (free-run target): cnt_clr pulse, count from 0.
    target = 4'd12;
    btn_start = 1'b1; step();
    check("t6_done_wait", done, 1);
    btn_start = 1'b0; step(); step();
    check("t6_restart_run", running, 1);
    check("t6_restart_clr", cnt_clr, 1);
    check("t6_restart_no_en", cnt_en, 0);

    // 2: free-run, wrap at 9, 30 steps, never DONE.
    en_cnt = 0; wrap_cnt = 0; done_seen = 0;
    for (int c = 0; c < 120; c++) begin
      if (cnt_en) en_cnt++;
      if (wrap_pulse) wrap_cnt++;
      if (done) done_seen = 1;
      if (c == 1) begin
        check("t2_cleared_val", cnt_value, 0);
        check("t2_clr_one_cycle", cnt_clr, 0);
      end
      if (c == 38) check("t2_no_wrap_early", wrap_pulse, 0);
      if (c == 39) begin
        check("t2_wrap_val", cnt_value, 9);
        check("t2_wrap_pulse", wrap_pulse, 1);
        check("t2_wrap_en", cnt_en, 1);
      end
      if (c == 40) check("t2_after_wrap", cnt_value, 0);
      step();
    end
    check("t2_en_count", en_cnt, 30);
    check("t2_wrap_count", wrap_cnt, 3);
    check("t2_never_done", done_seen, 0);

    // 3: pause at value 3 with presc frozen at 2, then resume.
    repeat (12) step();
    check("t3_val_at_stop", cnt_value, 3);
    btn_stop = 1'b1; step();
    btn_stop = 1'b0; step();
    check("t3_still_run", running, 1);
    step();
    check("t3_paused", running, 0);
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (cnt_en) en_cnt++;
      step();
    end
    check("t3_pause_no_en", en_cnt, 0);
    check("t3_pause_val", cnt_value, 3);
    btn_start = 1'b1; step();
    btn_start = 1'b0; step(); step();
    check("t3_resume_run", running, 1);
    check("t3_resume_no_en", cnt_en, 0);
    step();
    check("t3_resume_en", cnt_en, 1);
    check("t3_resume_en_val", cnt_value, 3);
    step();
    check("t3_resume_next_val", cnt_value, 4);

    // 4: clear and start together while RUN -> clear wins.
    btn_clear = 1'b1; btn_start = 1'b1; step();
    btn_clear = 1'b0; btn_start = 1'b0; step();
    check("t4_before_clear", running, 1);
    step();
    check("t4_idle", running, 0);
    check("t4_clr", cnt_clr, 1);
    check("t4_clr_no_en", cnt_en, 0);
    step();
    check("t4_clr_one_cycle", cnt_clr, 0);
    check("t4_val_zero", cnt_value, 0);
    repeat (4) step();
    check("t4_stays_idle", running, 0);
    btn_start = 1'b1; step();
    btn_start = 1'b0; step(); step();
    check("t4_start_alone", running, 1);

    // 5: held start gives one event; stop during the hold must stick.
    btn_clear = 1'b1; step();
    btn_clear = 1'b0; step(); step();
    check("t5_cleared", running, 0);
    step();
    for (int i = 0; i < 50; i++) begin
      if (i == 3)  check("t5_hold_run", running, 1);
      if (i == 13) check("t5_hold_paused", running, 0);
      if (i == 49) check("t5_hold_still_paused", running, 0);
      btn_start = 1'b1;
      btn_stop  = (i == 10);
      step();
    end
    btn_start = 1'b0; btn_stop = 1'b0;
    repeat (5) step();
    check("t5_release_no_evt", running, 0);
    btn_start = 1'b1; step();
    btn_start = 1'b0; step(); step();
    check("t5_rerun", running, 1);
    en_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (cnt_en) en_cnt++;
      btn_start = i[1];
      step();
    end
    btn_start = 1'b0;
    check("t5_toggle_en_count", en_cnt, 4);
    check("t5_toggle_running", running, 1);
    check("t5_toggle_done", done, 0);

    // 6: reset in RUN on a tick cycle.
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (cnt_en) found = 1;
      else step();
    end
    check("t6_tick_found", found, 1);
    reset = 1'b1; step();
    check("t6_rst_running", running, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_en", cnt_en, 0);
    check("t6_rst_clr", cnt_clr, 0);
    check("t6_rst_wrap", wrap_pulse, 0);
    check("t6_rst_val", cnt_value, 0);
    step();
    reset = 1'b0;
    repeat (3) step();
    check("t6_idle_after_rst", running, 0);
    check("t6_no_clr_after_rst", cnt_clr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
